// File: rtl/mm_responder_pkg.sv
// Shared address map, store-length encodings and region type for the
// mm_* data-access responder.
package mm_pkg;

  localparam logic [63:0] MEM_BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SERIAL_ADDR = 64'h0000_0000_A000_03F8;
  localparam logic [63:0] RTC_ADDR    = 64'h0000_0000_A000_0048;

  localparam logic [3:0] WLEN_B = 4'd1;
  localparam logic [3:0] WLEN_H = 4'd2;
  localparam logic [3:0] WLEN_W = 4'd4;
  localparam logic [3:0] WLEN_D = 4'd8;

  typedef enum logic [1:0] {REG_RAM, REG_SERIAL, REG_RTC, REG_NONE} region_e;

  // A RAM store is legal when the length is 1/2/4/8 and the byte offset is
  // naturally aligned to that length.
  function automatic logic ram_store_ok(input logic [3:0] wlen, input logic [2:0] off);
    logic ok;
    case (wlen)
      WLEN_B:  ok = 1'b1;
      WLEN_H:  ok = (off[0] == 1'b0);
      WLEN_W:  ok = (off[1:0] == 2'b00);
      WLEN_D:  ok = (off == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane enables for a store of wlen bytes starting at lane off.
  function automatic logic [7:0] lane_mask(input logic [3:0] wlen, input logic [2:0] off);
    logic [7:0] base;
    case (wlen)
      WLEN_B:  base = 8'h01;
      WLEN_H:  base = 8'h03;
      WLEN_W:  base = 8'h0F;
      WLEN_D:  base = 8'hFF;
      default: base = 8'h00;
    endcase
    return 8'(base << off);
  endfunction

endpackage

// File: rtl/mm_responder_if.sv
// Memory-stage data-access bus plus the serial TX stream and status flags.
interface mm_responder_if;
  logic [63:0] mm_addr;
  logic [63:0] mm_wdata;
  logic [3:0]  mm_wlen;
  logic        mm_wen;
  logic        mm_ren;
  logic [63:0] mm_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_overflow;
  logic        mm_fault;
  logic [63:0] fault_addr;

  // Initiator side: memory stage plus the serial consumer.
  modport master (
    output mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren, tx_ready,
    input  mm_rdata, tx_data, tx_valid, tx_overflow, mm_fault, fault_addr
  );

  // Responder side.
  modport slave (
    input  mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren, tx_ready,
    output mm_rdata, tx_data, tx_valid, tx_overflow, mm_fault, fault_addr
  );
endinterface

// File: rtl/mm_responder_tx_fifo.sv
// Synchronous FIFO with combinational head output; full/empty come from an
// extra wrap bit on each pointer. A push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointer arithmetic and handshake qualification.
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    dout_o  = mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/mm_responder.sv
// Target-side responder for mm_* accesses: 64-bit data RAM, serial TX
// queue, free-running cycle counter and a sticky first-fault recorder.
module mm_responder
  import mm_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int TXQ_DEPTH = 8
) (
  input  logic clk,
  input  logic rstn,
  mm_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [63:0]      ram_q [MEM_WORDS];
  logic [63:0]      rtc_q, rtc_d;
  logic             fault_q, fault_d;
  logic [63:0]      fault_addr_q, fault_addr_d;
  logic             ovf_q, ovf_d;

  logic [63:0]      off;
  logic [IDX_W-1:0] idx;
  region_e          region;
  logic             st, ld, store_ok, fault_now;
  logic             ram_we, rtc_we, push, pop, full, empty;
  logic [7:0]       lane_en;
  logic [63:0]      wdata_sh, rdata;
  logic [7:0]       fifo_dout;

  // Address decode: RAM range is checked via the offset from MEM_BASE.
  always_comb begin
    off = bus.mm_addr - MEM_BASE;
    idx = off[IDX_W+2:3];
    if (bus.mm_addr >= MEM_BASE && off[63:IDX_W+3] == '0) region = REG_RAM;
    else if (bus.mm_addr == SERIAL_ADDR)                   region = REG_SERIAL;
    else if (bus.mm_addr == RTC_ADDR)                      region = REG_RTC;
    else                                                   region = REG_NONE;
  end

  // Access qualification, fault detection and load data mux.
  always_comb begin
    st = bus.mm_wen && !bus.mm_ren;
    ld = bus.mm_ren && !bus.mm_wen;
    case (region)
      REG_RAM:    store_ok = ram_store_ok(bus.mm_wlen, off[2:0]);
      REG_SERIAL: store_ok = (bus.mm_wlen == WLEN_B);
      REG_RTC:    store_ok = (bus.mm_wlen == WLEN_D);
      default:    store_ok = 1'b0;
    endcase
    fault_now = (bus.mm_wen || bus.mm_ren) &&
                ((bus.mm_wen && bus.mm_ren) || region == REG_NONE || (st && !store_ok));
    ram_we   = st && store_ok && region == REG_RAM;
    rtc_we   = st && store_ok && region == REG_RTC;
    push     = st && store_ok && region == REG_SERIAL;
    lane_en  = lane_mask(bus.mm_wlen, off[2:0]);
    wdata_sh = bus.mm_wdata << {off[2:0], 3'b000};
    rdata    = '0;
    if (ld) begin
      case (region)
        REG_RAM:    rdata = ram_q[idx];
        REG_RTC:    rdata = rtc_q;
        REG_SERIAL: rdata = {63'b0, full};
        default:    rdata = '0;
      endcase
    end
  end

  // Next-state for counter, overflow and first-fault capture.
  always_comb begin
    rtc_d        = rtc_we ? bus.mm_wdata : rtc_q + 64'd1;
    ovf_d        = ovf_q || (push && full && !pop);
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (fault_now && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = bus.mm_addr;
    end
  end

  // Control/status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rtc_q        <= '0;
      ovf_q        <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      rtc_q        <= rtc_d;
      ovf_q        <= ovf_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Byte-lane RAM write; a store seen while reset is held is discarded.
  always_ff @(posedge clk) begin
    if (rstn && ram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (lane_en[b]) ram_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign pop = !empty && bus.tx_ready;

  tx_fifo #(.WIDTH(8), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (bus.mm_wdata[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.mm_rdata    = rdata;
  assign bus.tx_data     = fifo_dout;
  assign bus.tx_valid    = !empty;
  assign bus.tx_overflow = ovf_q;
  assign bus.mm_fault    = fault_q;
  assign bus.fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_mm_responder.sv
// Directed plus randomized bench for mm_responder against a byte/queue level
// reference model of the address map.
module tb_mm_responder;
  localparam logic [63:0] MB   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SER  = 64'h0000_0000_A000_03F8;
  localparam logic [63:0] RTC  = 64'h0000_0000_A000_0048;
  localparam int          WORDS = 4096;
  localparam int          DEPTH = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mm_responder_if bus ();

  mm_responder #(.MEM_WORDS(WORDS), .TXQ_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [63:0] ram_m [int];
  logic [7:0]  q_m [$];
  logic [63:0] rtc_m     = '0;
  logic        fault_m   = 1'b0;
  logic        ovf_m     = 1'b0;
  logic [63:0] faddr_m   = '0;
  logic [63:0] last_rd;
  logic [7:0]  last_txd;
  logic        last_txv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 = RAM, 1 = serial, 2 = counter, 3 = unmapped
  function automatic int region_of(input logic [63:0] a);
    if (a >= MB && a < MB + 64'(8 * WORDS)) return 0;
    if (a == SER) return 1;
    if (a == RTC) return 2;
    return 3;
  endfunction

  function automatic logic store_legal(input logic [63:0] a, input logic [3:0] wl);
    case (region_of(a))
      0: return (wl == 1 || wl == 2 || wl == 4 || wl == 8) && ((int'(a[2:0]) % int'(wl)) == 0);
      1: return wl == 1;
      2: return wl == 8;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: drive at posedge+1, check combinational outputs before
  // the edge, advance the model, check registered outputs after the edge.
  task automatic cycle(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] wl,
                       input logic we, input logic re, input logic rdy);
    int          r, idx;
    logic        legal, flt, pop, push, accept, chk;
    logic [63:0] exp_rd, w;
    bus.mm_addr = a; bus.mm_wdata = wd; bus.mm_wlen = wl;
    bus.mm_wen = we; bus.mm_ren = re; bus.tx_ready = rdy;
    #3;
    r      = region_of(a);
    idx    = int'((a - MB) >> 3);
    legal  = store_legal(a, wl);
    exp_rd = '0;
    chk    = 1'b1;
    if (re && !we) begin
      case (r)
        0: if (ram_m.exists(idx)) exp_rd = ram_m[idx]; else chk = 1'b0;
        1: exp_rd = 64'(q_m.size() == DEPTH);
        2: exp_rd = rtc_m;
        default: exp_rd = '0;
      endcase
    end
    last_rd  = bus.mm_rdata;
    last_txd = bus.tx_data;
    last_txv = bus.tx_valid;
    if (chk) check("rdata", bus.mm_rdata, exp_rd);
    check("tx_valid", 64'(bus.tx_valid), 64'(q_m.size() > 0));
    if (q_m.size() > 0) check("tx_data", 64'(bus.tx_data), 64'(q_m[0]));
    // model update for this edge
    flt = (we || re) && ((we && re) || r == 3 || (we && !re && !legal));
    if (flt && !fault_m) begin fault_m = 1'b1; faddr_m = a; end
    if (we && !re && r == 2 && legal) rtc_m = wd; else rtc_m = rtc_m + 64'd1;
    if (we && !re && r == 0 && legal) begin
      if (ram_m.exists(idx)) begin
        w = ram_m[idx];
        for (int k = 0; k < int'(wl); k++) w[8*(int'(a[2:0]) + k) +: 8] = wd[8*k +: 8];
        ram_m[idx] = w;
      end else if (wl == 8) begin
        ram_m[idx] = wd;
      end
    end
    pop    = (q_m.size() > 0) && rdy;
    push   = we && !re && r == 1 && legal;
    accept = push && (q_m.size() < DEPTH || pop);
    if (pop)            void'(q_m.pop_front());
    if (accept)         q_m.push_back(wd[7:0]);
    if (push && !accept) ovf_m = 1'b1;
    @(posedge clk); #1;
    check("mm_fault", 64'(bus.mm_fault), 64'(fault_m));
    check("fault_addr", bus.fault_addr, faddr_m);
    check("tx_overflow", 64'(bus.tx_overflow), 64'(ovf_m));
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] wl,
                    input logic rdy = 1'b0);
    cycle(a, wd, wl, 1'b1, 1'b0, rdy);
  endtask

  task automatic ld(input logic [63:0] a, input logic rdy = 1'b0);
    cycle(a, 64'd0, 4'd8, 1'b0, 1'b1, rdy);
  endtask

  task automatic idle(input logic rdy = 1'b0);
    cycle(64'd0, 64'd0, 4'd0, 1'b0, 1'b0, rdy);
  endtask

  // Called at posedge+1: asserts reset between edges, releases it after the
  // next edge so that edge sees reset low.
  task automatic do_reset(input logic mid);
    bus.mm_wen = 1'b0; bus.mm_ren = 1'b0; bus.tx_ready = 1'b0;
    #2; rstn = 1'b0; #1;
    if (mid) begin
      check("rst_async_fault", 64'(bus.mm_fault), 64'd0);
      check("rst_async_txv", 64'(bus.tx_valid), 64'd0);
    end
    q_m.delete();
    ovf_m = 1'b0; fault_m = 1'b0; faddr_m = '0; rtc_m = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a, wd;
    logic [3:0]  wl;
    logic [3:0]  wl_tab [8];
    int          sel;
    wl_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd3, 4'd0, 4'd1};
    bus.mm_addr = '0; bus.mm_wdata = '0; bus.mm_wlen = '0;
    bus.mm_wen = 1'b0; bus.mm_ren = 1'b0; bus.tx_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);
    check("rst_fault", 64'(bus.mm_fault), 64'd0);
    check("rst_ovf", 64'(bus.tx_overflow), 64'd0);
    check("rst_faddr", bus.fault_addr, 64'd0);
    ld(RTC);
    check("rtc_after_reset", last_rd, 64'd0);

    // full doubleword store then load
    st(64'h8000_0010, 64'h1122_3344_5566_7788, 4'd8);
    ld(64'h8000_0010);
    check("ram_dword", last_rd, 64'h1122_3344_5566_7788);

    // byte store into a zero word, then misaligned word store faults
    st(64'h8000_0010, 64'd0, 4'd8);
    st(64'h8000_0013, 64'hAB, 4'd1);
    ld(64'h8000_0010);
    check("ram_byte_lane3", last_rd, 64'h0000_0000_AB00_0000);
    st(64'h8000_0012, 64'hDEAD_BEEF, 4'd4);
    check("misalign_fault", 64'(bus.mm_fault), 64'd1);
    check("misalign_faddr", bus.fault_addr, 64'h8000_0012);
    ld(64'h8000_0010);
    check("misalign_nowrite", last_rd, 64'h0000_0000_AB00_0000);

    // full queue with simultaneous pop accepts the push
    for (int i = 0; i < 8; i++) st(SER, 64'(8'h30 + i), 4'd1);
    ld(SER);
    check("ser_full_a", last_rd, 64'd1);
    st(SER, 64'h5A, 4'd1, 1'b1);
    check("push_pop_noovf", 64'(bus.tx_overflow), 64'd0);
    ld(SER);
    check("ser_still_full", last_rd, 64'd1);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("drain_a", 64'(last_txd), (i < 7) ? 64'(8'h31 + i) : 64'h5A);
    end
    idle();
    check("drain_a_empty", 64'(last_txv), 64'd0);

    // overflow: ninth byte dropped
    for (int i = 0; i < 8; i++) st(SER, 64'(8'h41 + i), 4'd1);
    ld(SER);
    check("ser_full_b", last_rd, 64'd1);
    check("ovf_before", 64'(bus.tx_overflow), 64'd0);
    st(SER, 64'h49, 4'd1);
    check("ovf_after", 64'(bus.tx_overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      check("drain_b", 64'(last_txd), 64'(8'h41 + i));
    end
    idle();
    check("drain_b_empty", 64'(last_txv), 64'd0);

    // counter load and wrap
    st(RTC, 64'hFFFF_FFFF_FFFF_FFFE, 4'd8);
    ld(RTC); check("rtc_fe", last_rd, 64'hFFFF_FFFF_FFFF_FFFE);
    ld(RTC); check("rtc_ff", last_rd, 64'hFFFF_FFFF_FFFF_FFFF);
    ld(RTC); check("rtc_wrap", last_rd, 64'd0);
    st(RTC, 64'h1234, 4'd4);
    ld(RTC); check("rtc_bad_len", last_rd, 64'd2);

    // asynchronous reset with a byte pending
    st(SER, 64'h77, 4'd1);
    idle();
    check("pending_valid", 64'(last_txv), 64'd1);
    do_reset(1'b1);

    // unmapped load, then both enables
    st(64'h8000_0000, 64'h0123_4567_89AB_CDEF, 4'd8);
    ld(64'h9000_0000);
    check("unmapped_rd", last_rd, 64'd0);
    check("unmapped_fault", 64'(bus.mm_fault), 64'd1);
    check("unmapped_faddr", bus.fault_addr, 64'h9000_0000);
    cycle(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b1, 1'b1, 1'b0);
    check("both_rd", last_rd, 64'd0);
    check("both_faddr_kept", bus.fault_addr, 64'h9000_0000);
    ld(64'h8000_0000);
    check("both_nowrite", last_rd, 64'h0123_4567_89AB_CDEF);

    // RAM range boundaries
    st(64'h8000_7FF8, 64'hCAFE_F00D_0BAD_BEEF, 4'd8);
    ld(64'h8000_7FF8); check("ram_last_word", last_rd, 64'hCAFE_F00D_0BAD_BEEF);
    ld(64'h8000_8000); check("ram_end_unmapped", last_rd, 64'd0);
    ld(64'h7FFF_FFF8); check("ram_below_unmapped", last_rd, 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) st(MB + 64'(8 * i), {$urandom, $urandom}, 4'd8);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: a = MB + 64'($urandom_range(0, 127));
        5:             a = SER;
        6:             a = RTC;
        7:             a = 64'h9000_0000 + 64'($urandom_range(0, 7));
        8:             a = MB + 64'(8 * WORDS) + 64'($urandom_range(0, 15));
        default:       a = MB - 64'd1 - 64'($urandom_range(0, 7));
      endcase
      wd  = {$urandom, $urandom};
      wl  = wl_tab[$urandom_range(0, 7)];
      sel = $urandom_range(0, 9);
      if (sel < 4)       cycle(a, wd, wl, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      else if (sel < 8)  cycle(a, wd, wl, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      else if (sel == 8) cycle(a, wd, wl, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      else               idle(1'($urandom_range(0, 1)));
    end
    do_reset(1'b1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mm_responder.md
Name: mm_responder

Overview:
- Target-side responder for the memory stage's mm_* data-access interface. The memory stage initiates; this block answers.
- Contents: MEM_WORDS x 64-bit data RAM, a byte-wide serial TX queue, and a free-running 64-bit cycle counter (RTC).
- Reads return combinationally in the same cycle. Writes commit on the clock edge.
- A sticky fault flag records the first illegal access.

Parameters:
- MEM_BASE, 64'h8000_0000, byte base address of the data RAM
- MEM_WORDS, 4096, RAM depth in 64-bit words (power of two)
- SERIAL_ADDR, 64'hA000_03F8, serial data/status register address
- RTC_ADDR, 64'hA000_0048, cycle counter address
- TXQ_DEPTH, 8, serial queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- mm_addr  in  64  byte address of the access
- mm_wdata  in  64  store data, right-aligned (byte 0 = wdata[7:0])
- mm_wlen  in  4  store length in bytes: 1, 2, 4 or 8
- mm_wen  in  1  store request this cycle
- mm_ren  in  1  load request this cycle
- mm_rdata  out  64  load data: the aligned doubleword containing mm_addr
- tx_data  out  8  serial byte at the queue head
- tx_valid  out  1  queue not empty
- tx_ready  in  1  consumer accepts tx_data this cycle
- tx_overflow  out  1  sticky: a serial byte was dropped
- mm_fault  out  1  sticky illegal-access flag
- fault_addr  out  64  mm_addr of the first fault

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values: tx_valid=0, tx_overflow=0, mm_fault=0, fault_addr=0, counter=0, queue pointers=0. RAM contents are not reset.
- Region decode: RAM when MEM_BASE <= addr < MEM_BASE+8*MEM_WORDS; SERIAL when addr==SERIAL_ADDR; RTC when addr==RTC_ADDR; all other addresses are unmapped.
- Loads (mm_ren=1, mm_wen=0), zero latency, no alignment check:
  - RAM: word index (addr-MEM_BASE)>>3.
  - RTC: current counter value.
  - SERIAL: {63'b0, queue_full}.
  - Unmapped: 64'h0 and fault.
  - mm_ren=0: mm_rdata=0.
- RAM stores:
  - Legal wlen is 1, 2, 4 or 8, and addr[2:0] must be a multiple of wlen.
  - Bytes written are lanes addr[2:0] through addr[2:0]+wlen-1, taking wdata bytes 0..wlen-1.
  - Written on the posedge; visible to a load in the next cycle, not the same cycle.
  - Illegal wlen or misaligned: no write, fault.
- SERIAL store:
  - wlen must be 1, else fault and no push.
  - Pushes wdata[7:0] on the edge.
  - Push is accepted if the queue is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
- RTC:
  - Counter increments by 1 every cycle and wraps 2^64-1 -> 0.
  - Store with wlen=8 loads wdata; this takes precedence over the increment, and increments resume the following cycle.
  - Store with other wlen: fault, no change.
  - Load returns the pre-edge value.
- Serial queue:
  - Pop when tx_valid & tx_ready.
  - No fall-through: a push into an empty queue raises tx_valid the next cycle.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - Simultaneous push and pop on a non-empty queue keeps the count unchanged.
- Fault conditions:
  - mm_wen & mm_ren both high: no write and no push; mm_rdata=0.
  - Unmapped address with either enable.
  - Illegal or misaligned store as defined above.
- Fault recording: on the first fault edge mm_fault<=1 and fault_addr<=mm_addr. Later faults do not update fault_addr. Both clear only on reset.
- Reset asserted mid-operation: the queue empties immediately and the counter restarts from 0. A store in the same cycle as reset release is ignored only if rstn is low at the edge.

Decomposition:
- Shared package mm_pkg holds:
  - Address-map constants MEM_BASE, SERIAL_ADDR, RTC_ADDR.
  - Length encodings WLEN_B=1, WLEN_H=2, WLEN_W=4, WLEN_D=8.
  - Region-enum typedef {REG_RAM, REG_SERIAL, REG_RTC, REG_NONE}.
- One sub-module, tx_fifo: parameterised synchronous FIFO with full/empty via an extra pointer bit and async active-low reset.

Test Plan:
- Store 0x1122334455667788 with wlen=8 at 0x80000010, then load 0x80000010 next cycle -> rdata=0x1122334455667788. A load in the same cycle as the store returns the old word.
- Store 0xAB with wlen=1 at 0x80000013 over a word of 0 -> load 0x80000010 returns 0x00000000AB000000. Store wlen=4 at 0x80000012 -> no write, mm_fault=1, fault_addr=0x80000012.
- Push 9 bytes 0x41..0x49 to SERIAL_ADDR with tx_ready=0 (TXQ_DEPTH=8) -> status bit0=1 after 8 pushes, tx_overflow=1, 0x49 dropped. Raise tx_ready -> tx_data streams 0x41..0x48, then tx_valid=0.
- With the queue full and tx_ready=1, push 0x5A in the same cycle -> accepted, no overflow, count stays 8.
- Store 0xFFFFFFFFFFFFFFFE with wlen=8 to RTC_ADDR, then load on the next two cycles -> 0xFFFFFFFFFFFFFFFE, then 0xFFFFFFFFFFFFFFFF; the cycle after that reads 0.
- Load 0x90000000 -> rdata=0, mm_fault=1, fault_addr=0x90000000. Then assert wen&ren at 0x80000000 -> RAM unchanged, fault_addr stays 0x90000000. Assert rstn=0 asynchronously between edges -> mm_fault=0 and tx_valid=0 at once.
